// File: rtl/reg_file_sb_pkg.sv
// Shared definitions for the scoreboarded register file and the decode/hazard logic around it.
// Latency: none (constants and a pure helper function).
// Backpressure: none.
package reg_file_sb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Index of the hardwired zero register.
  localparam int unsigned ZERO_IDX = 0;

  // An address is usable unless it names the hardwired zero register.
  function automatic logic addr_legal(input logic [31:0] addr, input logic zero_reg);
    return !(zero_reg && (addr == ZERO_IDX));
  endfunction

endpackage

// File: rtl/reg_file_sb_popcount.sv
// sb_popcount: population count of an N-bit vector.
// Latency: combinational; the caller registers the result.
// Backpressure: none. Ports: vec (input vector), cnt (number of set bits).
module sb_popcount #(
  parameter int N = 32,
  parameter int W = 6
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + W'(vec[i]);
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2R/1W register file with write-to-read bypass, optional zero register and busy scoreboard.
// Latency: 1 cycle on both read ports, busy flags and busy_cnt; a same-cycle write is bypassed.
// Backpressure: none; every operation completes at the edge. Ports: elk/nrst, rd_addrA/B -> rd_dataA/B,
//   rd_busyA/B, wr_en/wr_addr/wr_data (write + release), rsv_en/rsv_addr (reserve), busy_cnt.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              elk,
  input  logic              nrst,
  input  logic [ADDR_W-1:0] rd_addrA,
  input  logic [ADDR_W-1:0] rd_addrB,
  output logic [DATA_W-1:0] rd_dataA,
  output logic [DATA_W-1:0] rd_dataB,
  output logic              rd_busyA,
  output logic              rd_busyB,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic [ADDR_W:0]   cnt_next;
  logic              wr_ok;
  logic              rsv_ok;

  assign wr_ok  = wr_en  && addr_legal(32'(wr_addr),  ZERO_REG);
  assign rsv_ok = rsv_en && addr_legal(32'(rsv_addr), ZERO_REG);

  // Reservation is applied after the release so that a producer reusing
  // its destination in the same cycle keeps the register busy.
  always_comb begin
    busy_next = busy;
    if (wr_ok) begin
      busy_next[wr_addr] = 1'b0;
    end
    if (rsv_ok) begin
      busy_next[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge elk) begin
    if (!nrst) begin
      busy     <= '0;
      busy_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
      if (wr_ok) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  sb_popcount #(
    .N (DEPTH),
    .W (ADDR_W + 1)
  ) u_popcount (
    .vec (busy_next),
    .cnt (cnt_next)
  );

  logic [ADDR_W-1:0] port_addr [2];
  assign port_addr[0] = rd_addrA;
  assign port_addr[1] = rd_addrB;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DATA_W-1:0] data_q;
    logic              busy_q;
    logic              hit;
    logic              is_zero;

    assign is_zero = !addr_legal(32'(port_addr[p]), ZERO_REG);
    assign hit     = wr_ok && (wr_addr == port_addr[p]);

    // Busy is taken from busy_next so issue logic sees this cycle's
    // reservation/release without a one-cycle blind spot.
    always_ff @(posedge elk) begin
      if (!nrst || is_zero) begin
        data_q <= '0;
        busy_q <= 1'b0;
      end else begin
        data_q <= hit ? wr_data : mem[port_addr[p]];
        busy_q <= busy_next[port_addr[p]];
      end
    end
  end

  assign rd_dataA = g_port[0].data_q;
  assign rd_dataB = g_port[1].data_q;
  assign rd_busyA = g_port[0].busy_q;
  assign rd_busyB = g_port[1].busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

  logic        elk;
  logic        nrst;
  logic        wr_en, rsv_en;

  // default instance: 32-bit x 32
  logic [4:0]  rd_addrA, rd_addrB, wr_addr, rsv_addr;
  logic [31:0] wr_data, rd_dataA, rd_dataB;
  logic        rd_busyA, rd_busyB;
  logic [5:0]  busy_cnt;

  // small instance: 16-bit x 8
  logic [2:0]  rd_addrA_s, rd_addrB_s, wr_addr_s, rsv_addr_s;
  logic [15:0] wr_data_s, rd_dataA_s, rd_dataB_s;
  logic        rd_busyA_s, rd_busyB_s;
  logic [3:0]  busy_cnt_s;

  int n_cmp = 0;
  int n_bad = 0;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) u_dut (
    .elk(elk), .nrst(nrst),
    .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .rd_dataA(rd_dataA), .rd_dataB(rd_dataB),
    .rd_busyA(rd_busyA), .rd_busyB(rd_busyB),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_cnt(busy_cnt)
  );

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1)) u_dut_s (
    .elk(elk), .nrst(nrst),
    .rd_addrA(rd_addrA_s), .rd_addrB(rd_addrB_s),
    .rd_dataA(rd_dataA_s), .rd_dataB(rd_dataB_s),
    .rd_busyA(rd_busyA_s), .rd_busyB(rd_busyB_s),
    .wr_en(wr_en), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr_s),
    .busy_cnt(busy_cnt_s)
  );

  initial begin
    elk = 1'b0;
    forever #5 elk = ~elk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: plain arrays, index 0 = default instance, 1 = small.
  logic [31:0] m_mem  [2][32];
  bit          m_busy [2][32];
  logic [31:0] e_da [2], e_db [2];
  bit          e_ba [2], e_bb [2];
  int          e_cnt [2];

  task automatic model(input int k, input bit rst_n, input bit wen, input int wa,
                       input logic [31:0] wd, input bit ren, input int ra,
                       input int a, input int b);
    int          dep;
    logic [31:0] dm;
    bit          wl, rl;
    dep = (k == 0) ? 32 : 8;
    dm  = (k == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    wa = wa % dep; ra = ra % dep; a = a % dep; b = b % dep; wd = wd & dm;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[k][i] = '0;
        m_busy[k][i] = 1'b0;
      end
      e_da[k] = '0; e_db[k] = '0; e_ba[k] = 1'b0; e_bb[k] = 1'b0; e_cnt[k] = 0;
      return;
    end
    wl = wen && (wa != 0);
    rl = ren && (ra != 0);
    e_da[k] = (a == 0) ? 32'h0 : ((wl && wa == a) ? wd : m_mem[k][a]);
    e_db[k] = (b == 0) ? 32'h0 : ((wl && wa == b) ? wd : m_mem[k][b]);
    if (wl) begin
      m_mem[k][wa]  = wd;
      m_busy[k][wa] = 1'b0;
    end
    if (rl) m_busy[k][ra] = 1'b1;
    e_ba[k] = (a == 0) ? 1'b0 : m_busy[k][a];
    e_bb[k] = (b == 0) ? 1'b0 : m_busy[k][b];
    e_cnt[k] = 0;
    for (int i = 0; i < dep; i++) e_cnt[k] += int'(m_busy[k][i]);
  endtask

  // One clock: drive at the falling edge, let the rising edge sample, check at the next falling edge.
  task automatic cyc(input bit rst_n, input bit wen, input int wa, input logic [31:0] wd,
                     input bit ren, input int ra, input int a, input int b);
    logic [31:0] g_da [2], g_db [2], g_cnt [2];
    logic        g_ba [2], g_bb [2];
    nrst = rst_n; wr_en = wen; rsv_en = ren;
    wr_addr = 5'(wa);   rsv_addr = 5'(ra);   rd_addrA = 5'(a);   rd_addrB = 5'(b);   wr_data = wd;
    wr_addr_s = 3'(wa); rsv_addr_s = 3'(ra); rd_addrA_s = 3'(a); rd_addrB_s = 3'(b); wr_data_s = wd[15:0];
    model(0, rst_n, wen, wa, wd, ren, ra, a, b);
    model(1, rst_n, wen, wa, wd, ren, ra, a, b);
    @(posedge elk);
    @(negedge elk);
    g_da[0] = rd_dataA;         g_db[0] = rd_dataB;         g_ba[0] = rd_busyA;   g_bb[0] = rd_busyB;
    g_cnt[0] = 32'(busy_cnt);
    g_da[1] = 32'(rd_dataA_s);  g_db[1] = 32'(rd_dataB_s);  g_ba[1] = rd_busyA_s; g_bb[1] = rd_busyB_s;
    g_cnt[1] = 32'(busy_cnt_s);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("i%0d_dataA", k), g_da[k], e_da[k]);
      chk($sformatf("i%0d_dataB", k), g_db[k], e_db[k]);
      chk($sformatf("i%0d_busyA", k), 32'(g_ba[k]), 32'(e_ba[k]));
      chk($sformatf("i%0d_busyB", k), 32'(g_bb[k]), 32'(e_bb[k]));
      chk($sformatf("i%0d_cnt", k), g_cnt[k], 32'(e_cnt[k]));
    end
  endtask

  initial begin
    nrst = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
    wr_addr = '0; rsv_addr = '0; rd_addrA = '0; rd_addrB = '0; wr_data = '0;
    wr_addr_s = '0; rsv_addr_s = '0; rd_addrA_s = '0; rd_addrB_s = '0; wr_data_s = '0;
    @(negedge elk);

    // Reset, including reset winning over a write.
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 5, 32'hDEADBEEF, 1, 6, 5, 6);
    cyc(0, 1, 5, 32'hDEADBEEF, 1, 6, 5, 6);
    chk("rst_r5_data", rd_dataA, 32'h0);
    chk("rst_cnt", 32'(busy_cnt), 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 5, 6);
    chk("rst_r5_after", rd_dataA, 32'h0);
    chk("rst_r6_busy", 32'(rd_busyB), 32'h0);

    // Write then read one cycle later.
    cyc(1, 1, 7, 32'h12345678, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 7, 0);
    chk("lat_r7", rd_dataA, 32'h12345678);

    // Bypass on both ports.
    cyc(1, 1, 3, 32'hA5A5A5A5, 0, 0, 3, 3);
    chk("byp_A", rd_dataA, 32'hA5A5A5A5);
    chk("byp_B", rd_dataB, 32'hA5A5A5A5);
    chk("byp_busy", {31'h0, rd_busyA | rd_busyB}, 32'h0);

    // Scoreboard: reserve, write+reserve, write.
    cyc(1, 0, 0, 0, 1, 9, 9, 9);
    chk("sb_rsv_busy", 32'(rd_busyA), 32'h1);
    chk("sb_rsv_cnt", 32'(busy_cnt), 32'h1);
    cyc(1, 1, 9, 32'hCAFEF00D, 1, 9, 9, 9);
    chk("sb_wr_rsv_busy", 32'(rd_busyA), 32'h1);
    chk("sb_wr_rsv_data", rd_dataA, 32'hCAFEF00D);
    cyc(1, 1, 9, 32'h0BADC0DE, 0, 0, 9, 9);
    chk("sb_wr_busy", 32'(rd_busyA), 32'h0);
    chk("sb_wr_cnt", 32'(busy_cnt), 32'h0);
    chk("sb_wr_data", rd_dataA, 32'h0BADC0DE);

    // Zero register ignores writes and reservations.
    cyc(1, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
    chk("zr_data", rd_dataA, 32'h0);
    chk("zr_busy", 32'(rd_busyA), 32'h0);
    chk("zr_cnt", 32'(busy_cnt), 32'h0);

    // Small instance: reserve all 7 legal registers, then release one by one.
    for (int i = 1; i < 8; i++) cyc(1, 0, 0, 0, 1, i, i, 0);
    chk("sw_full_cnt", 32'(busy_cnt_s), 32'd7);
    for (int i = 1; i < 8; i++) begin
      cyc(1, 1, i, 32'(i * 32'h1111), 0, 0, i, i);
      chk($sformatf("sw_cnt_%0d", i), 32'(busy_cnt_s), 32'(7 - i));
      chk($sformatf("sw_data_%0d", i), 32'(rd_dataA_s), 32'(i * 32'h1111) & 32'hFFFF);
    end

    // Random traffic with occasional reset.
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 63) != 0), 1'($urandom), int'($urandom_range(0, 31)), $urandom,
          1'($urandom), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
